// File: rtl/cntry_vehicle_sensor.sv
// Country-road vehicle queue model feeding the light controller's x request, plus a light-safety monitor.
// Latency: all outputs registered, one edge after the causing input. Backpressure: none; arrivals at a full queue are dropped.
module cntry_vehicle_sensor #(
   parameter int MAX_Q      = 15,
   parameter int CW         = 4,
   parameter int DEPART_CYC = 3
) (
   input  logic          clk,
   input  logic          clear,
   input  logic          car_arrive,
   input  logic [1:0]    hwy,
   input  logic [1:0]    cntry,
   output logic          x,
   output logic [CW-1:0] queue_cnt,
   output logic          depart,
   output logic          overflow,
   output logic          safety_err
);

   localparam int            TW    = (DEPART_CYC > 1) ? $clog2(DEPART_CYC) : 1;
   localparam logic [CW-1:0] QMAX  = CW'(MAX_Q);
   localparam logic [TW-1:0] TLAST = TW'(DEPART_CYC - 1);
   localparam logic [1:0]    RED   = 2'd0;
   localparam logic [1:0]    GREEN = 2'd2;
   localparam logic [1:0]    ILL   = 2'd3;

   typedef enum logic [1:0] {IDLE, WAITING, SERVING} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   queue_q, queue_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            x_q, x_d;
   logic            depart_q, depart_d;
   logic            ovf_q, ovf_d;
   logic            serr_q, serr_d;
   logic            dep;

   always_comb begin
      queue_d  = queue_q;
      ovf_d    = ovf_q;
      state_d  = state_q;
      timer_d  = '0;
      // SERVING always implies a non-empty queue, so a departure can never underflow.
      dep      = (state_q == SERVING) && (timer_q == TLAST);
      depart_d = dep;

      if (car_arrive && !dep) begin
         if (queue_q == QMAX) ovf_d = 1'b1;
         else                 queue_d = queue_q + 1'b1;
      end else if (!car_arrive && dep) begin
         queue_d = queue_q - 1'b1;
      end

      if (queue_d == '0)         state_d = IDLE;
      else if (cntry == GREEN)   state_d = SERVING;
      else                       state_d = WAITING;

      // Count continues only while staying in SERVING; any (re)entry starts from zero.
      if ((state_q == SERVING) && (state_d == SERVING) && !dep)
         timer_d = timer_q + 1'b1;

      x_d    = (queue_d != '0);
      serr_d = serr_q || (hwy == ILL) || (cntry == ILL) ||
               ((hwy != RED) && (cntry != RED));
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_q  <= IDLE;
         queue_q  <= '0;
         timer_q  <= '0;
         x_q      <= 1'b0;
         depart_q <= 1'b0;
         ovf_q    <= 1'b0;
         serr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         queue_q  <= queue_d;
         timer_q  <= timer_d;
         x_q      <= x_d;
         depart_q <= depart_d;
         ovf_q    <= ovf_d;
         serr_q   <= serr_d;
      end
   end

   assign x          = x_q;
   assign queue_cnt  = queue_q;
   assign depart     = depart_q;
   assign overflow   = ovf_q;
   assign safety_err = serr_q;

endmodule

// File: tb/tb_cntry_vehicle_sensor.sv
// Directed bench for cntry_vehicle_sensor: stimulus pushes hand-computed per-edge expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_cntry_vehicle_sensor;

   localparam logic [1:0] R = 2'd0, Y = 2'd1, G = 2'd2, BAD = 2'd3;

   typedef struct packed {
      logic [3:0] q;
      logic       x;
      logic       d;
      logic       o;
      logic       s;
   } exp_t;

   logic       clk = 1'b0;
   logic       clear = 1'b0;
   logic       car_arrive = 1'b0;
   logic [1:0] hwy = G;
   logic [1:0] cntry = R;
   logic       x;
   logic [3:0] queue_cnt;
   logic       depart;
   logic       overflow;
   logic       safety_err;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   logic e_ovf = 1'b0;
   logic e_serr = 1'b0;
   int   edge_no = 0;

   cntry_vehicle_sensor #(.MAX_Q(15), .CW(4), .DEPART_CYC(3)) dut (
      .clk(clk), .clear(clear), .car_arrive(car_arrive), .hwy(hwy), .cntry(cntry),
      .x(x), .queue_cnt(queue_cnt), .depart(depart), .overflow(overflow), .safety_err(safety_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input exp_t e);
      exp_t a;
      a = '{q: queue_cnt, x: x, d: depart, o: overflow, s: safety_err};
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got q=%0d x=%b dep=%b ovf=%b serr=%b, want q=%0d x=%b dep=%b ovf=%b serr=%b",
                  name, a.q, a.x, a.d, a.o, a.s, e.q, e.x, e.d, e.o, e.s);
      end
   endtask

   // One clock edge of stimulus together with the outputs expected after it.
   task automatic step(input logic arr, input logic [1:0] h, input logic [1:0] c,
                       input int eq, input logic ed);
      exp_t e;
      car_arrive = arr;
      hwy        = h;
      cntry      = c;
      e = '{q: 4'(eq), x: (eq != 0), d: ed, o: e_ovf, s: e_serr};
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Drain n vehicles on country green: entry edge, then a departure every third edge.
   task automatic drain(input int n);
      step(1'b0, R, G, n, 1'b0);
      for (int i = n - 1; i >= 0; i--) begin
         step(1'b0, R, G, i + 1, 1'b0);
         step(1'b0, R, G, i + 1, 1'b0);
         step(1'b0, R, G, i, 1'b1);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            edge_no++;
            check($sformatf("edge%0d", edge_no), e);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

   initial begin : stim
      #1;
      check("reset_state", '{q: 4'd0, x: 1'b0, d: 1'b0, o: 1'b0, s: 1'b0});
      repeat (2) @(negedge clk);
      clear = 1'b1;

      // Three arrivals with country red.
      step(1'b1, G, R, 1, 1'b0);
      step(1'b1, G, R, 2, 1'b0);
      step(1'b1, G, R, 3, 1'b0);

      // Country green: departures on the 3rd edge after entry, then every 3 edges.
      drain(3);
      step(1'b0, R, G, 0, 1'b0);

      // Yellow interruption abandons the count; re-entry restarts it.
      step(1'b1, R, R, 1, 1'b0);
      step(1'b1, R, R, 2, 1'b0);
      step(1'b0, R, G, 2, 1'b0);
      step(1'b0, R, G, 2, 1'b0);
      step(1'b0, R, Y, 2, 1'b0);
      step(1'b0, R, G, 2, 1'b0);
      step(1'b0, R, G, 2, 1'b0);
      step(1'b0, R, G, 2, 1'b0);
      step(1'b0, R, G, 1, 1'b1);

      // Arrival coincident with a departure at queue=1, then drain the last one.
      step(1'b0, R, G, 1, 1'b0);
      step(1'b0, R, G, 1, 1'b0);
      step(1'b1, R, G, 1, 1'b1);
      step(1'b0, R, G, 1, 1'b0);
      step(1'b0, R, G, 1, 1'b0);
      step(1'b0, R, G, 0, 1'b1);

      // Fill to capacity without overflow.
      for (int k = 1; k <= 15; k++) step(1'b1, G, R, k, 1'b0);
      // Coincident arrival and departure at full: count holds, no overflow.
      step(1'b0, R, G, 15, 1'b0);
      step(1'b0, R, G, 15, 1'b0);
      step(1'b0, R, G, 15, 1'b0);
      step(1'b1, R, G, 15, 1'b1);
      // Arrivals at full with no departure are dropped and flag overflow.
      e_ovf = 1'b1;
      step(1'b1, G, R, 15, 1'b0);
      step(1'b1, G, R, 15, 1'b0);
      // Overflow stays set through a complete drain.
      drain(15);

      // Safety monitor: both lights non-red, then an illegal code.
      step(1'b1, G, R, 1, 1'b0);
      step(1'b1, G, R, 2, 1'b0);
      e_serr = 1'b1;
      step(1'b0, G, Y, 2, 1'b0);
      step(1'b0, G, BAD, 2, 1'b0);
      step(1'b0, G, R, 2, 1'b0);

      // Asynchronous reset mid-cycle clears everything at once.
      @(negedge clk);
      #2;
      clear = 1'b0;
      #1;
      check("async_clear", '{q: 4'd0, x: 1'b0, d: 1'b0, o: 1'b0, s: 1'b0});
      #1;
      clear = 1'b1;
      e_ovf  = 1'b0;
      e_serr = 1'b0;
      step(1'b1, G, R, 1, 1'b0);
      step(1'b0, G, R, 1, 1'b0);

      for (int t = 0; t < 20 && sb.size() > 0; t++) @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain_scoreboard: %0d expectations left, want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
